pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen_if.sv | 10 +
 rtl/pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_pattern_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_if.sv
// Pixel FIFO write port: generator drives write strobe and RGB565 data,
// the FIFO answers with its almost-full flag.
interface pattern_gen_if;
  logic        fifo_write;
  logic [15:0] fifo_data;
  logic        fifo_full;

  modport master (output fifo_write, output fifo_data, input fifo_full);
  modport slave  (input fifo_write, input fifo_data, output fifo_full);
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern generator streaming one RGB565 frame per vtrigger into a FIFO.
// Optional sticky overrun detection is built only when PATTERN_GEN_OVERRUN_EN is defined.
module pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BORDER    = 8,
  parameter int CELL_LOG2 = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vtrigger,
  input  logic [1:0]         mode,
  input  logic [15:0]        solid_rgb,
  pattern_gen_if.master      fifo,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic [31:0] BORDER_U    = 32'(BORDER);
  localparam logic [31:0] X_BORDER_HI = 32'(H_ACTIVE - BORDER);
  localparam logic [31:0] Y_BORDER_HI = 32'(V_ACTIVE - BORDER);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [BW-1:0] bar_cnt_reg, bar_cnt_next;
  logic [2:0]    bar_idx_reg, bar_idx_next;
  logic [1:0]    mode_reg, mode_next;
  logic [15:0]   rgb_reg, rgb_next;
  logic          fifo_write_reg;
  logic [15:0]   fifo_data_reg;
  logic          frame_done_reg;

  logic          emit;
  logic          last_pix;
  logic [15:0]   pixel;
  logic [31:0]   x_ext, y_ext;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  // Next-state: counters advance only on cycles that actually emit a pixel.
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    bar_cnt_next = bar_cnt_reg;
    bar_idx_next = bar_idx_reg;
    mode_next    = mode_reg;
    rgb_next     = rgb_reg;
    emit         = 1'b0;
    last_pix     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vtrigger) begin
          state_next   = ACTIVE;
          x_next       = '0;
          y_next       = '0;
          bar_cnt_next = '0;
          bar_idx_next = '0;
          mode_next    = mode;
          rgb_next     = solid_rgb;
        end
      end
      ACTIVE: begin
        if (!fifo.fifo_full) begin
          emit = 1'b1;
          if (x_reg == X_LAST) begin
            x_next       = '0;
            bar_cnt_next = '0;
            bar_idx_next = '0;
            if (y_reg == Y_LAST) begin
              last_pix   = 1'b1;
              state_next = IDLE;
              y_next     = '0;
            end else begin
              y_next = y_reg + YW'(1);
            end
          end else begin
            x_next = x_reg + XW'(1);
            if (bar_cnt_reg == BAR_LAST) begin
              bar_cnt_next = '0;
              bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
              bar_cnt_next = bar_cnt_reg + BW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel colour for the current (x, y); coordinates are zero-extended so
  // gradient bit slices above the counter width read as 0.
  always_comb begin
    x_ext = 32'(x_reg);
    y_ext = 32'(y_reg);
    pixel = 16'h0000;
    case (mode_reg)
      2'd0: begin
        if (x_ext < BORDER_U || y_ext < BORDER_U ||
            x_ext >= X_BORDER_HI || y_ext >= Y_BORDER_HI)
          pixel = 16'h001F;
        else if (x_ext[CELL_LOG2-1:0] == '0 || y_ext[CELL_LOG2-1:0] == '0)
          pixel = 16'hF800;
        else if (x_ext[CELL_LOG2] ^ y_ext[CELL_LOG2])
          pixel = 16'hFFFF;
        else
          pixel = 16'h0000;
      end
      2'd1:    pixel = bar_colour(bar_idx_reg);
      2'd2:    pixel = {x_ext[8:4], y_ext[8:3], ~x_ext[8:4]};
      default: pixel = rgb_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      bar_cnt_reg    <= '0;
      bar_idx_reg    <= '0;
      mode_reg       <= '0;
      rgb_reg        <= '0;
      fifo_write_reg <= 1'b0;
      fifo_data_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      bar_cnt_reg    <= bar_cnt_next;
      bar_idx_reg    <= bar_idx_next;
      mode_reg       <= mode_next;
      rgb_reg        <= rgb_next;
      fifo_write_reg <= emit;
      frame_done_reg <= last_pix;
      if (emit)
        fifo_data_reg <= pixel;
    end
  end

  assign fifo.fifo_write = fifo_write_reg;
  assign fifo.fifo_data  = fifo_data_reg;
  assign busy            = (state_reg == ACTIVE);
  assign frame_done      = frame_done_reg;

`ifdef PATTERN_GEN_OVERRUN_EN
  // A frame request arriving while still generating means the timing block
  // outran the generator; remember it until the next reset.
  logic overrun_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun_reg <= 1'b0;
    else if (state_reg == ACTIVE && vtrigger)
      overrun_reg <= 1'b1;
  end
  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen on a reduced 64x24 raster: table of pixel
// vectors per mode plus hand sequences for reset, mid-frame and last-pixel events.
module tb_pattern_gen;

  localparam int H    = 64;
  localparam int V    = 24;
  localparam int BRD  = 8;
  localparam int CL   = 3;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        vtrigger;
  logic [1:0]  mode;
  logic [15:0] solid_rgb;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  pattern_gen_if fif ();

  pattern_gen #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .BORDER    (BRD),
    .CELL_LOG2 (CL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vtrigger   (vtrigger),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .fifo       (fif),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] cap [$];
  int          done_cnt  = 0;
  int          done_at   = 0;
  logic        done_busy = 1'b0;
  logic        done_wr   = 1'b0;
  logic [15:0] frm [4][NPIX];

  // Write monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (fif.fifo_write === 1'b1)
      cap.push_back(fif.fifo_data);
    if (frame_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_at   = cap.size();
      done_busy = busy;
      done_wr   = fif.fifo_write;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int m, input int x, input int y, input logic [15:0] rgb);
    logic [15:0] bars [8];
    logic [4:0]  r;
    logic [5:0]  g;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (m)
      0: begin
        if (x < BRD || y < BRD || x >= H - BRD || y >= V - BRD) return 16'h001F;
        if ((x % (1 << CL)) == 0 || (y % (1 << CL)) == 0)       return 16'hF800;
        if ((((x >> CL) & 1) ^ ((y >> CL) & 1)) != 0)            return 16'hFFFF;
        return 16'h0000;
      end
      1: return bars[x / (H / 8)];
      2: begin
        r = 5'((x >> 4) & 31);
        g = 6'((y >> 3) & 63);
        return {r, g, ~r};
      end
      default: return rgb;
    endcase
  endfunction

  task automatic start_frame(input logic [1:0] m, input logic [15:0] rgb);
    @(posedge clk); #1;
    mode = m; solid_rgb = rgb; vtrigger = 1'b1;
    @(posedge clk); #1;
    vtrigger = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string name);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk); #1;
      if (rnd) fif.fifo_full = 1'($urandom_range(0, 1));
      c = c + 1;
    end
    fif.fifo_full = 1'b0;
    if (done_cnt == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_writes(input int n, input string name);
    int c;
    c = 0;
    while (cap.size() < n && c < 4 * NPIX) begin
      @(negedge clk); #1;
      c = c + 1;
    end
    if (cap.size() < n) chk({name, "_wtimeout"}, cap.size(), n);
  endtask

  task automatic frame_checks(input int m, input logic [15:0] rgb, input string name);
    int errs;
    chk({name, "_count"}, cap.size(), NPIX);
    chk({name, "_done_at"}, done_at, NPIX);
    chk({name, "_done_with_write"}, done_wr, 1);
    chk({name, "_busy_at_done"}, done_busy, 0);
    @(negedge clk); #1;
    chk({name, "_no_extra"}, cap.size(), NPIX);
    errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i >= cap.size() || cap[i] !== exp_pix(m, i % H, i / H, rgb)) errs = errs + 1;
      if (i < cap.size()) frm[m][i] = cap[i];
    end
    chk({name, "_sweep_errs"}, errs, 0);
    $display("frame %s mode=%0d writes=%0d", name, m, cap.size());
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [15:0] rgb, input bit rnd, input string name);
    cap.delete();
    done_cnt = 0;
    start_frame(m, rgb);
    wait_done(4 * NPIX + 20, rnd, name);
    frame_checks(int'(m), rgb, name);
  endtask

  typedef struct {
    string       nm;
    int          m;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [18];
  logic expect_ovr;

  initial begin
    int errs;

    vt[0]  = '{"m0_origin",   0,  0,  0, 16'h001F};
    vt[1]  = '{"m0_grid",     0,  8,  8, 16'hF800};
    vt[2]  = '{"m0_black",    0,  9,  9, 16'h0000};
    vt[3]  = '{"m0_white",    0, 17,  9, 16'hFFFF};
    vt[4]  = '{"m0_last",     0, 63, 23, 16'h001F};
    vt[5]  = '{"m0_rborder",  0, 56, 12, 16'h001F};
    vt[6]  = '{"m0_vgrid",    0, 32, 10, 16'hF800};
    vt[7]  = '{"m0_black2",   0, 30, 14, 16'h0000};
    vt[8]  = '{"m0_white2",   0, 20, 12, 16'hFFFF};
    vt[9]  = '{"m1_first",    1,  0,  0, 16'hFFFF};
    vt[10] = '{"m1_bar0_end", 1,  7,  5, 16'hFFFF};
    vt[11] = '{"m1_bar1",     1,  8,  5, 16'hFFE0};
    vt[12] = '{"m1_bar2",     1, 16,  3, 16'h07FF};
    vt[13] = '{"m1_bar5",     1, 40,  3, 16'hF800};
    vt[14] = '{"m1_last",     1, 63, 23, 16'h0000};
    vt[15] = '{"m2_16_8",     2, 16,  8, 16'h083E};
    vt[16] = '{"m2_40_17",    2, 40, 17, 16'h105D};
    vt[17] = '{"m3_solid",    3,  5,  5, 16'h1234};

`ifdef PATTERN_GEN_OVERRUN_EN
    expect_ovr = 1'b1;
`else
    expect_ovr = 1'b0;
`endif

    // Reset state
    reset = 1'b1; vtrigger = 1'b0; mode = 2'd0; solid_rgb = 16'h0000; fif.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_write", fif.fifo_write, 0);
    chk("rst_fifo_data", fif.fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_writes", cap.size(), 0);
    chk("idle_busy", busy, 0);

    // Mid-frame reset abandons the frame; a fresh vtrigger restarts at (0,0)
    cap.delete(); done_cnt = 0;
    start_frame(2'd3, 16'hABCD);
    wait_writes(20, "pre_reset");
    reset = 1'b1;
    #1;
    chk("midrst_fifo_write", fif.fifo_write, 0);
    chk("midrst_fifo_data", fif.fifo_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cap.delete();
    repeat (10) @(negedge clk);
    chk("after_rst_no_resume", cap.size(), 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_done", done_cnt, 0);
    run_frame(2'd3, 16'h1234, 1'b0, "solid");

    // Checkerboard / border frame
    run_frame(2'd0, 16'h0000, 1'b0, "checker");

    // Mode change and extra vtrigger mid-frame: frame must stay checkerboard
    cap.delete(); done_cnt = 0;
    start_frame(2'd0, 16'h0000);
    wait_writes(100, "modechg");
    mode = 2'd2;
    vtrigger = 1'b1;
    @(posedge clk); #1;
    vtrigger = 1'b0;
    wait_done(NPIX + 20, 1'b0, "modechg");
    chk("modechg_count", cap.size(), NPIX);
    errs = 0;
    for (int i = 0; i < NPIX; i++)
      if (i >= cap.size() || cap[i] !== frm[0][i]) errs = errs + 1;
    chk("modechg_stays_mode0", errs, 0);
    chk("overrun_after_midframe_vtrig", overrun, 32'(expect_ovr));
    $display("frame modechg writes=%0d overrun=%0b", cap.size(), overrun);

    // Gradient, then colour bars under random back-pressure
    run_frame(2'd2, 16'h0000, 1'b0, "gradient");
    run_frame(2'd1, 16'h0000, 1'b1, "bars_rand_full");

    // vtrigger coinciding with the final pixel must not start another frame
    cap.delete(); done_cnt = 0;
    start_frame(2'd3, 16'h5A5A);
    wait_writes(NPIX - 1, "lastpix");
    chk("lastpix_pre_count", cap.size(), NPIX - 1);
    vtrigger = 1'b1;
    @(posedge clk); #1;
    vtrigger = 1'b0;
    repeat (6) @(negedge clk);
    chk("lastpix_count", cap.size(), NPIX);
    chk("lastpix_done_cnt", done_cnt, 1);
    chk("lastpix_idle", busy, 0);
    chk("lastpix_overrun", overrun, 32'(expect_ovr));

    // Table of directed pixel vectors against captured frames
    for (int k = 0; k < 18; k++) begin
      chk(vt[k].nm, frm[vt[k].m][vt[k].y * H + vt[k].x], vt[k].exp);
      $display("vec %s mode=%0d (%0d,%0d) got %h", vt[k].nm, vt[k].m, vt[k].x, vt[k].y,
               frm[vt[k].m][vt[k].y * H + vt[k].x]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
